// File: rtl/contador_descendente_mc.sv
// contador_descendente_mc: multi-channel down counter with per-channel IDLE/RUN/DONE FSM,
//   one-shot or periodic reload, terminal-count pulse and sticky underflow flag.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load, load_ch       load strobe and target channel (out-of-range index ignored)
//   load_value          value written to the channel's count and reload registers
//   auto_reload[i]      1 = periodic (reload on terminal count), 0 = one-shot
//   sub[i]              per-channel decrement enable
//   step                decrement amount shared by all channels
//   clear_flags         clears all underflow flags
//   count               registered counters, channel i at [i*REG_WIDTH +: REG_WIDTH]
//   zero                combinational count==0 per channel
//   tc_pulse            registered one-cycle terminal-count pulse
//   underflow           registered sticky flag: step exceeded remaining count
//   busy                any channel in RUN
module contador_descendente_mc #(
   parameter int REG_WIDTH  = 8,
   parameter int CHANNELS   = 4,
   parameter int STEP_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [3:0]                    load_ch,
   input  logic [REG_WIDTH-1:0]          load_value,
   input  logic [CHANNELS-1:0]           auto_reload,
   input  logic [CHANNELS-1:0]           sub,
   input  logic [STEP_WIDTH-1:0]         step,
   input  logic                          clear_flags,
   output logic [CHANNELS*REG_WIDTH-1:0] count,
   output logic [CHANNELS-1:0]           zero,
   output logic [CHANNELS-1:0]           tc_pulse,
   output logic [CHANNELS-1:0]           underflow,
   output logic                          busy
);
   // Comparisons run at the wider of the two widths so a step wider than the
   // counter still compares correctly as an unsigned value.
   localparam int AW = (REG_WIDTH > STEP_WIDTH) ? REG_WIDTH : STEP_WIDTH;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   logic [AW-1:0]       step_w;
   logic                step_nz;
   logic [CHANNELS-1:0] running;
   assign step_w  = AW'(step);
   assign step_nz = |step;
   assign busy    = |running;
   for (genvar c = 0; c < CHANNELS; c++) begin : ch
      state_t               st, st_nx;
      logic [REG_WIDTH-1:0] cnt, cnt_nx, rld, rld_nx;
      logic [AW-1:0]        cnt_w;
      logic                 tc_q, tc_nx, uf_q, uf_nx;
      logic                 hit, dec, term, under, run;
      assign cnt_w = AW'(cnt);
      // Indices >= CHANNELS never match any channel, so such loads are dropped.
      assign hit   = load && (load_ch == 4'(c));
      assign dec   = (st == RUN) && sub[c] && step_nz;
      assign term  = dec && (cnt_w <= step_w);
      assign under = dec && (cnt_w < step_w);
      always_ff @(posedge clk) begin
         if (rst) begin
            st   <= IDLE;
            cnt  <= '0;
            rld  <= '0;
            tc_q <= 1'b0;
            uf_q <= 1'b0;
         end else begin
            st   <= st_nx;
            cnt  <= cnt_nx;
            rld  <= rld_nx;
            tc_q <= tc_nx;
            uf_q <= uf_nx;
         end
      end
      always_comb begin
         st_nx = hit ? ((|load_value) ? RUN : DONE) :
                 (term && !auto_reload[c]) ? DONE : st;
      end
      // Load wins over a same-cycle decrement; terminal count either reloads
      // (periodic) or saturates at zero (one-shot), never wrapping.
      always_comb begin
         cnt_nx = hit  ? load_value :
                  term ? (auto_reload[c] ? rld : '0) :
                  dec  ? cnt - REG_WIDTH'(step_w) : cnt;
         rld_nx = hit ? load_value : rld;
         tc_nx  = term && !hit;
         uf_nx  = (under && !hit) || (uf_q && !clear_flags);
      end
      always_comb begin
         run = (st == RUN);
      end
      assign running[c]                          = run;
      assign zero[c]                             = (cnt == '0);
      assign tc_pulse[c]                         = tc_q;
      assign underflow[c]                        = uf_q;
      assign count[c*REG_WIDTH +: REG_WIDTH]     = cnt;
   end
endmodule

// File: tb/tb_contador_descendente_mc.sv
// tb_contador_descendente_mc: directed scenarios plus random traffic checked against a behavioural model.
module tb_contador_descendente_mc;
   localparam int RW = 8;
   localparam int CH = 4;
   localparam int SW = 4;
   logic            clk = 0;
   logic            rst, load, clear_flags;
   logic [3:0]      load_ch;
   logic [RW-1:0]   load_value;
   logic [CH-1:0]   auto_reload, sub;
   logic [SW-1:0]   step;
   logic [CH*RW-1:0] count;
   logic [CH-1:0]   zero, tc_pulse, underflow;
   logic            busy;
   int checks = 0, errors = 0;
   int m_cnt [CH];
   int m_rld [CH];
   int m_mode[CH];
   int m_tc  [CH];
   int m_uf  [CH];
   contador_descendente_mc #(.REG_WIDTH(RW), .CHANNELS(CH), .STEP_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .load(load), .load_ch(load_ch), .load_value(load_value),
      .auto_reload(auto_reload), .sub(sub), .step(step), .clear_flags(clear_flags),
      .count(count), .zero(zero), .tc_pulse(tc_pulse), .underflow(underflow), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Model modes: 0 idle, 1 counting, 2 finished.
   task automatic model_step();
      for (int i = 0; i < CH; i++) begin
         int  s;
         int  set_uf;
         bit  hit;
         s      = int'(step);
         set_uf = 0;
         hit    = load && (int'(load_ch) == i);
         if (rst) begin
            m_cnt[i] = 0; m_rld[i] = 0; m_mode[i] = 0; m_tc[i] = 0; m_uf[i] = 0;
         end else begin
            m_tc[i] = 0;
            if (hit) begin
               m_cnt[i]  = int'(load_value);
               m_rld[i]  = int'(load_value);
               m_mode[i] = (load_value != 0) ? 1 : 2;
            end else if (m_mode[i] == 1 && sub[i] && s > 0) begin
               if (m_cnt[i] > s) m_cnt[i] = m_cnt[i] - s;
               else begin
                  m_tc[i] = 1;
                  set_uf  = (m_cnt[i] < s) ? 1 : 0;
                  if (auto_reload[i]) m_cnt[i] = m_rld[i];
                  else begin
                     m_cnt[i]  = 0;
                     m_mode[i] = 2;
                  end
               end
            end
            m_uf[i] = (set_uf != 0 || (m_uf[i] != 0 && !clear_flags)) ? 1 : 0;
         end
      end
   endtask
   task automatic tick();
      logic [CH*RW-1:0] e_cnt;
      logic [CH-1:0]    e_zero, e_tc, e_uf;
      logic             e_busy;
      model_step();
      e_busy = 0;
      for (int i = 0; i < CH; i++) begin
         e_cnt[i*RW +: RW] = RW'(m_cnt[i]);
         e_zero[i] = (m_cnt[i] == 0);
         e_tc[i]   = (m_tc[i] != 0);
         e_uf[i]   = (m_uf[i] != 0);
         if (m_mode[i] == 1) e_busy = 1;
      end
      @(posedge clk);
      #1;
      chk("count", 64'(count), 64'(e_cnt));
      chk("zero", 64'(zero), 64'(e_zero));
      chk("tc_pulse", 64'(tc_pulse), 64'(e_tc));
      chk("underflow", 64'(underflow), 64'(e_uf));
      chk("busy", 64'(busy), 64'(e_busy));
   endtask
   task automatic do_load(input int c, input int v);
      load = 1; load_ch = 4'(c); load_value = RW'(v);
   endtask
   initial begin
      rst = 1; load = 0; load_ch = 0; load_value = 0; auto_reload = 0;
      sub = 0; step = 0; clear_flags = 0;
      for (int i = 0; i < CH; i++) begin
         m_cnt[i] = 0; m_rld[i] = 0; m_mode[i] = 0; m_tc[i] = 0; m_uf[i] = 0;
      end
      tick(); tick();
      chk("reset_zero", 64'(zero), 64'hF);
      chk("reset_busy", 64'(busy), 64'h0);
      rst = 0;
      // One-shot countdown from 5 with step 1.
      do_load(0, 5); auto_reload = 4'b0000; step = 1; sub = 4'b0001;
      tick();
      chk("s34_load", 64'(count[7:0]), 64'd5);
      load = 0;
      for (int k = 4; k >= 0; k--) begin
         tick();
         chk("s34_cnt", 64'(count[7:0]), 64'(k));
      end
      chk("s34_tc", 64'(tc_pulse[0]), 64'h1);
      chk("s34_busy", 64'(busy), 64'h0);
      tick();
      chk("s34_tc_off", 64'(tc_pulse[0]), 64'h0);
      // Periodic ch1 from 7 with step 3.
      do_load(1, 7); auto_reload = 4'b0010; step = 3; sub = 4'b0010;
      tick();
      load = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("s35_cnt", 64'(count[15:8]), (k % 3 == 0) ? 64'd4 : (k % 3 == 1) ? 64'd1 : 64'd7);
         chk("s35_tc", 64'(tc_pulse[1]), (k % 3 == 2) ? 64'h1 : 64'h0);
         if (k == 2) chk("s35_uf", 64'(underflow[1]), 64'h1);
      end
      // Zero step holds ch2, then an exact terminal step.
      do_load(2, 10); step = 0; sub = 4'b0100;
      tick();
      load = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("s36_hold", 64'(count[23:16]), 64'd10);
         chk("s36_tc0", 64'(tc_pulse[2]), 64'h0);
      end
      step = 10;
      tick();
      chk("s36_cnt", 64'(count[23:16]), 64'd0);
      chk("s36_tc", 64'(tc_pulse[2]), 64'h1);
      chk("s36_uf", 64'(underflow[2]), 64'h0);
      // Load beats sub in the same cycle; out-of-range load ignored.
      do_load(0, 1); sub = 4'b0000; step = 1;
      tick();
      do_load(0, 9); sub = 4'b0001;
      tick();
      chk("s37_cnt", 64'(count[7:0]), 64'd9);
      chk("s37_tc", 64'(tc_pulse[0]), 64'h0);
      do_load(15, 33); sub = 4'b0000;
      tick();
      chk("s37_ign", 64'(count[7:0]), 64'd9);
      // Underflow sticky versus clear_flags.
      load = 0; step = 12; sub = 4'b0001;
      tick();
      chk("s38_set", 64'(underflow[0]), 64'h1);
      do_load(0, 3); sub = 4'b0000;
      tick();
      load = 0; step = 5; sub = 4'b0001; clear_flags = 1;
      tick();
      chk("s38_win", 64'(underflow[0]), 64'h1);
      sub = 4'b0000;
      tick();
      chk("s38_clr", 64'(underflow[0]), 64'h0);
      clear_flags = 0;
      // Reset mid-count abandons ch3.
      do_load(3, 6); step = 1; sub = 4'b1000;
      tick();
      load = 0;
      tick(); tick();
      rst = 1;
      tick();
      chk("s39_cnt", 64'(count), 64'h0);
      chk("s39_tc", 64'(tc_pulse), 64'h0);
      chk("s39_zero", 64'(zero[3]), 64'h1);
      chk("s39_busy", 64'(busy), 64'h0);
      rst = 0;
      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         rst         = ($urandom_range(0, 99) == 0);
         load        = ($urandom_range(0, 3) == 0);
         load_ch     = 4'($urandom_range(0, 5) == 0 ? $urandom_range(4, 15) : $urandom_range(0, 3));
         load_value  = RW'($urandom_range(0, 4) == 0 ? 0 : ($urandom_range(0, 1) ? $urandom_range(1, 20) : $urandom));
         if ($urandom_range(0, 15) == 0) auto_reload = 4'($urandom);
         sub         = 4'($urandom);
         step        = 4'($urandom);
         clear_flags = ($urandom_range(0, 7) == 0);
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/contador_descendente_mc.md
CONTADOR_DESCENDENTE_MC -- requirements
Module: contador_descendente_mc

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 8, bit width of each channel counter and reload register.
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of independent down-counter channels (range 1..16).
REQ-003 The block SHALL have parameter STEP_WIDTH, default 4, bit width of the decrement step.
REQ-004 The block SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 The block SHALL have port load, input, 1, load strobe for channel load_ch.
REQ-007 The block SHALL have port load_ch, input, 4, index of the channel to load.
REQ-008 The block SHALL have port load_value, input, REG_WIDTH, value for the count and reload registers.
REQ-009 The block SHALL have port auto_reload, input, CHANNELS, per-channel mode (1 = periodic, 0 = one-shot).
REQ-010 The block SHALL have port sub, input, CHANNELS, per-channel decrement enable.
REQ-011 The block SHALL have port step, input, STEP_WIDTH, decrement amount shared by all channels.
REQ-012 The block SHALL have port clear_flags, input, 1, clears all underflow flags.
REQ-013 The block SHALL have port count, output, CHANNELS*REG_WIDTH, registered counters; channel i in bits [i*REG_WIDTH +: REG_WIDTH].
REQ-014 The block SHALL have port zero, output, CHANNELS, combinational count==0 per channel.
REQ-015 The block SHALL have port tc_pulse, output, CHANNELS, registered one-cycle terminal-count pulse.
REQ-016 The block SHALL have port underflow, output, CHANNELS, registered sticky flag, step exceeded remaining count.
REQ-017 The block SHALL have port busy, output, 1, OR of all channels in state RUN.

Function
REQ-018 Each channel SHALL implement its own FSM with states IDLE, RUN and DONE.
REQ-019 On load with load_ch < CHANNELS: count and reload of that channel SHALL take load_value; state goes to RUN if load_value != 0, otherwise to DONE with no tc_pulse.
REQ-020 A load with load_ch >= CHANNELS SHALL be ignored, with no state change.
REQ-021 Load SHALL take priority over sub on the same channel in the same cycle; that cycle's decrement is discarded.
REQ-022 In RUN with sub[i]=1 and count > step: count SHALL become count - step on the next edge.
REQ-023 In RUN with sub[i]=1, step != 0 and count <= step: tc_pulse[i] SHALL be 1 for exactly the next cycle; if count < step, underflow[i] SHALL also set.
REQ-024 In the REQ-023 case with auto_reload[i]=1: count SHALL take reload[i] and the channel SHALL stay in RUN; count never reads 0 in that case.
REQ-025 In the REQ-023 case with auto_reload[i]=0: count SHALL saturate to 0 and the channel SHALL go to DONE, never wrapping.
REQ-026 A step of 0 SHALL leave count and state unchanged and produce no pulse.
REQ-027 In IDLE or DONE, sub SHALL be ignored; only load leaves these states.
REQ-028 Arithmetic SHALL zero-extend step to REG_WIDTH; comparisons SHALL be unsigned.
REQ-029 Channels SHALL be fully independent; simultaneous terminal counts SHALL pulse simultaneously.
REQ-030 clear_flags SHALL clear all underflow bits next edge; a new underflow in the same cycle wins (bit stays 1).
REQ-031 tc_pulse SHALL be 0 in every cycle not covered by REQ-023.

Reset
REQ-032 While rst=1 at an edge, all counts and reloads SHALL go to 0, states to IDLE, and tc_pulse, underflow and busy to 0; zero SHALL then read all ones.
REQ-033 rst SHALL override load, sub and clear_flags in the same cycle; reset mid-count SHALL abandon the count with no tc_pulse.

Verification
REQ-034 The bench SHALL cover this scenario: load ch0=5, auto_reload=0, step=1, sub[0] held -> count 4,3,2,1,0; tc_pulse[0] on the cycle count reads 0; DONE; busy drops.
REQ-035 The bench SHALL cover this scenario: load ch1=7, auto_reload=1, step=3, sub held -> count 4,1,7,4,1,7; tc_pulse on each 1->7 transition; underflow[1]=1 after the first 1->7.
REQ-036 The bench SHALL cover this scenario: load ch2=10, step=0, sub held for 4 cycles -> count stays 10, no pulse; then step=10 -> count 0, tc_pulse, underflow=0.
REQ-037 The bench SHALL cover this scenario: sub[0]=1 and load ch0=9 in the same cycle while count=1 -> count=9, no tc_pulse; load_ch=15 with CHANNELS=4 -> no change.
REQ-038 The bench SHALL cover this scenario: ch0 underflow set, then clear_flags=1 in the same cycle as a new ch0 underflow -> underflow[0] stays 1; next cycle clear_flags alone -> 0.
REQ-039 The bench SHALL cover this scenario: rst=1 mid-count with ch3=6 -> next cycle count=0, IDLE, tc_pulse=0, zero[3]=1, busy=0.
